// File: rtl/ddc_usb_streamer.sv
// Read-side DDC FIFO consumer: serialises 128-bit IQ words onto the FX3 slave-FIFO bus,
// frames them into fixed-size USB packets and commits short packets with PKTEND.
module ddc_usb_streamer #(
    parameter int WIDTH_IN  = 128,
    parameter int WIDTH_BUS = 32,
    parameter int PKT_WORDS = 1024
) (
    input  logic                 clk_rd,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rdempty,
    input  logic [WIDTH_IN-1:0]  q_data,
    input  logic                 pktend_req,
    input  logic                 change_task,
    input  logic                 fx_ready,
    output logic                 strobe_rd,
    output logic [WIDTH_BUS-1:0] fx_data,
    output logic                 fx_wr,
    output logic                 fx_pktend,
    output logic [15:0]          pkt_count,
    output logic [7:0]           debug
);

    localparam int CNT_W = $clog2(PKT_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_WORDS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SEND   = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;

    logic [2:0]          state;
    logic [CNT_W-1:0]    word_cnt;
    logic [1:0]          lane;
    logic [WIDTH_IN-1:0] shreg;
    logic                pend;
    logic                pf_reg;
    logic                run_en;

    logic                start_ok;
    logic                prefetch;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    cnt_eff;
    logic [WIDTH_BUS-1:0] lane_word [4];

    // run_en keeps the read strobe low while rst is held, even with data waiting
    always_comb begin
        start_ok = 1'b0;
        if (run_en && state == ST_IDLE && !change_task && enable && !rdempty)
            start_ok = (word_cnt != '0) || fx_ready;
    end

    always_comb begin
        prefetch = 1'b0;
        if (state == ST_SEND && lane == 2'd2 && !change_task && enable && !rdempty)
            prefetch = (int'(word_cnt) + 2) != PKT_WORDS;
    end

    // Word count after this cycle; a SEND cycle still puts a word on the bus
    always_comb begin
        cnt_inc = (word_cnt == CNT_LAST) ? '0 : word_cnt + 1'b1;
        case (state)
            ST_SEND:   cnt_eff = cnt_inc;
            ST_COMMIT: cnt_eff = '0;
            default:   cnt_eff = word_cnt;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            lane_word[i] = shreg[i*WIDTH_BUS +: WIDTH_BUS];
    end

    assign strobe_rd = start_ok || prefetch;
    assign fx_wr     = (state == ST_SEND);
    assign fx_pktend = (state == ST_COMMIT);
    assign fx_data   = fx_wr ? lane_word[lane] : '0;
    assign debug     = {state, pend, fx_ready & run_en, rdempty & run_en, strobe_rd, fx_pktend};

    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            lane      <= 2'd0;
            shreg     <= '0;
            pend      <= 1'b0;
            pf_reg    <= 1'b0;
            run_en    <= 1'b0;
            pkt_count <= 16'd0;
        end else begin
            run_en <= 1'b1;
            pf_reg <= prefetch;

            if (state == ST_SEND) begin
                word_cnt <= cnt_inc;
                if (word_cnt == CNT_LAST)
                    pkt_count <= pkt_count + 16'd1;
            end else if (state == ST_COMMIT) begin
                word_cnt  <= '0;
                pkt_count <= pkt_count + 16'd1;
            end

            if (change_task)
                pend <= 1'b0;
            else if (pktend_req)
                pend <= 1'b1;
            else if (state == ST_COMMIT || (state == ST_IDLE && pend && rdempty && word_cnt == '0))
                pend <= 1'b0;

            if (change_task) begin
                state <= (cnt_eff != '0) ? ST_COMMIT : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_ok)
                            state <= ST_LOAD;
                        else if (pend && rdempty && word_cnt != '0)
                            state <= ST_COMMIT;
                    end
                    ST_LOAD: begin
                        shreg <= q_data;
                        lane  <= 2'd0;
                        state <= ST_SEND;
                    end
                    ST_SEND: begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            if (pf_reg)
                                shreg <= q_data;
                            else
                                state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddc_usb_streamer.sv
// Directed bench for ddc_usb_streamer: FIFO model feeds a bus-word scoreboard; packet
// framing, PKTEND, backpressure, change_task, enable drop and async reset are checked.
module tb_ddc_usb_streamer;

    localparam int W = 32;

    logic           clk_rd = 1'b0;
    logic           rst;
    logic           enable;
    logic           rdempty;
    logic [127:0]   q_data;
    logic           pktend_req;
    logic           change_task;
    logic           fx_ready;
    logic           strobe_rd;
    logic [W-1:0]   fx_data;
    logic           fx_wr;
    logic           fx_pktend;
    logic [15:0]    pkt_count;
    logic [7:0]     debug;

    ddc_usb_streamer dut (
        .clk_rd      (clk_rd),
        .rst         (rst),
        .enable      (enable),
        .rdempty     (rdempty),
        .q_data      (q_data),
        .pktend_req  (pktend_req),
        .change_task (change_task),
        .fx_ready    (fx_ready),
        .strobe_rd   (strobe_rd),
        .fx_data     (fx_data),
        .fx_wr       (fx_wr),
        .fx_pktend   (fx_pktend),
        .pkt_count   (pkt_count),
        .debug       (debug)
    );

    always #5 clk_rd = ~clk_rd;

    logic [127:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int wr_cnt, rd_cnt, pe_cnt, first_wr_cyc, last_wr_cyc;
    int sb_err = 0;
    int underflow = 0;
    logic [W-1:0] word0, word3;
    logic [127:0] q0;
    logic pop_pending;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clr_stats();
        wr_cnt = 0; rd_cnt = 0; pe_cnt = 0; first_wr_cyc = 0; last_wr_cyc = 0;
    endtask

    task automatic fifo_push(input int n);
        logic [127:0] w;
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) q0 = w;
            fifo_q.push_back(w);
        end
        rdempty = (fifo_q.size() == 0);
    endtask

    // Sample at the falling edge, then model the FIFO just after the rising edge
    task automatic tick();
        logic [127:0] w;
        @(negedge clk_rd);
        cyc++;
        pop_pending = strobe_rd;
        if (strobe_rd) rd_cnt++;
        if (fx_pktend) begin
            pe_cnt++;
            check("pktend_wr_low", 64'(fx_wr), 64'd0);
        end
        if (fx_wr) begin
            if (wr_cnt == 0) begin first_wr_cyc = cyc; word0 = fx_data; end
            if (wr_cnt == 3) word3 = fx_data;
            last_wr_cyc = cyc;
            wr_cnt++;
            if (exp_q.size() == 0) sb_err++;
            else check("fx_data", 64'(fx_data), 64'(exp_q.pop_front()));
        end
        @(posedge clk_rd);
        #1;
        if (pop_pending) begin
            if (fifo_q.size() == 0) underflow++;
            else begin
                w = fifo_q.pop_front();
                q_data = w;
                for (int l = 0; l < 4; l++) exp_q.push_back(w[32*l +: 32]);
            end
        end
        rdempty = (fifo_q.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_wr(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && wr_cnt < target; i++) tick();
        check(tag, 64'(wr_cnt), 64'(target));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_strobe"}, 64'(strobe_rd), 64'd0);
        check({tag, "_fx_wr"}, 64'(fx_wr), 64'd0);
        check({tag, "_pktend"}, 64'(fx_pktend), 64'd0);
        check({tag, "_fx_data"}, 64'(fx_data), 64'd0);
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
        check({tag, "_debug"}, 64'(debug), 64'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; fx_ready = 1'b1; rdempty = 1'b1;
        q_data = '0; pktend_req = 1'b0; change_task = 1'b0;
        clr_stats();
        run(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        run(3);

        // T1: full packet
        fifo_push(256);
        clr_stats();
        run(1040);
        check("t1_wr_cnt", 64'(wr_cnt), 64'd1024);
        check("t1_contiguous", 64'(last_wr_cyc - first_wr_cyc + 1), 64'd1024);
        check("t1_rd_cnt", 64'(rd_cnt), 64'd256);
        check("t1_pkt_count", 64'(pkt_count), 64'd1);
        check("t1_no_pktend", 64'(pe_cnt), 64'd0);
        check("t1_word0", 64'(word0), 64'(q0[31:0]));
        check("t1_word3", 64'(word3), 64'(q0[127:96]));

        // T2: short burst committed by pktend_req
        fifo_push(10);
        clr_stats();
        run(50);
        pktend_req = 1'b1;
        tick();
        pktend_req = 1'b0;
        run(5);
        check("t2_wr_cnt", 64'(wr_cnt), 64'd40);
        check("t2_rd_cnt", 64'(rd_cnt), 64'd10);
        check("t2_pktend", 64'(pe_cnt), 64'd1);
        check("t2_pkt_count", 64'(pkt_count), 64'd2);

        // T3: backpressure before a packet, ignored mid-packet
        fx_ready = 1'b0;
        fifo_push(256);
        clr_stats();
        run(20);
        check("t3_hold_rd", 64'(rd_cnt), 64'd0);
        check("t3_hold_wr", 64'(wr_cnt), 64'd0);
        fx_ready = 1'b1;
        tick();
        check("t3_start_rd", 64'(rd_cnt), 64'd1);
        run(100);
        fx_ready = 1'b0;
        run(940);
        check("t3_wr_cnt", 64'(wr_cnt), 64'd1024);
        check("t3_contiguous", 64'(last_wr_cyc - first_wr_cyc + 1), 64'd1024);
        check("t3_rd_cnt", 64'(rd_cnt), 64'd256);
        check("t3_pkt_count", 64'(pkt_count), 64'd3);
        fx_ready = 1'b1;

        // T4: change_task in SEND lane 1 after 37 words
        fifo_push(20);
        clr_stats();
        wait_wr(37, 200, "t4_reach_37");
        change_task = 1'b1;
        tick();
        change_task = 1'b0;
        check("t4_no_strobe", 64'(rd_cnt), 64'd10);
        tick();
        check("t4_wr_dropped", 64'(wr_cnt), 64'd38);
        check("t4_pktend", 64'(pe_cnt), 64'd1);
        check("t4_pkt_count", 64'(pkt_count), 64'd4);
        check("t4_truncated_lanes", 64'(exp_q.size()), 64'd2);
        exp_q.delete();

        // Restart from word 0: a full packet with pktend_req on its last word
        fifo_push(246);
        clr_stats();
        wait_wr(1023, 1100, "t5_reach_1023");
        pktend_req = 1'b1;
        tick();
        pktend_req = 1'b0;
        run(20);
        check("t5_wr_cnt", 64'(wr_cnt), 64'd1024);
        check("t5_contiguous", 64'(last_wr_cyc - first_wr_cyc + 1), 64'd1024);
        check("t5_rd_cnt", 64'(rd_cnt), 64'd256);
        check("t5_no_zlp", 64'(pe_cnt), 64'd0);
        check("t5_pkt_count", 64'(pkt_count), 64'd5);

        // T5b: enable drop in lane 1, then resume without the watermark
        fifo_push(8);
        clr_stats();
        wait_wr(5, 50, "t5b_reach_5");
        enable = 1'b0;
        run(20);
        check("t5b_wr_cnt", 64'(wr_cnt), 64'd8);
        check("t5b_rd_cnt", 64'(rd_cnt), 64'd2);
        check("t5b_no_pktend", 64'(pe_cnt), 64'd0);
        fx_ready = 1'b0;
        enable = 1'b1;
        run(40);
        check("t5b_resume_wr", 64'(wr_cnt), 64'd32);
        check("t5b_resume_rd", 64'(rd_cnt), 64'd8);

        // T6: async reset mid-SEND, then a clean packet
        fifo_push(16);
        clr_stats();
        wait_wr(6, 50, "t6_reach_6");
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("t6_async");
        fifo_q.delete();
        exp_q.delete();
        q_data = '0;
        fifo_push(256);
        run(2);
        rst = 1'b0;
        fx_ready = 1'b1;
        clr_stats();
        run(1040);
        check("t6_wr_cnt", 64'(wr_cnt), 64'd1024);
        check("t6_contiguous", 64'(last_wr_cyc - first_wr_cyc + 1), 64'd1024);
        check("t6_rd_cnt", 64'(rd_cnt), 64'd256);
        check("t6_pkt_count", 64'(pkt_count), 64'd1);
        check("t6_word0", 64'(word0), 64'(q0[31:0]));

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("sb_unexpected_wr", 64'(sb_err), 64'd0);
        check("fifo_underflow", 64'(underflow), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
